// File: rtl/chip8_pkg.sv
// Shared definitions for the CHIP-8 call/return controller: FSM states,
// stack command encodings and the default stack depth.
package chip8_pkg;

    localparam int DEPTH_DEFAULT = 16;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_PUSH = 2'b01;
    localparam logic [1:0] WE_POP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_A,
        PUSH_B,
        POP_A,
        POP_B,
        POP_WAIT,
        DONE
    } state_t;

    // CHIP-8 instructions are two bytes; the PC wraps at 16 bits.
    function automatic logic [15:0] next_instr(input logic [15:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/chip8_call_ret_ctrl.sv
// CHIP-8 2NNN/00EE sequencer: drives a two-cycle push/pop handshake to an
// external stack, tracks occupancy and flags overflow/underflow.
//
// state    | meaning
// IDLE     | waiting for call_req / ret_req
// PUSH_A   | first push cycle, return address on stk_writedata
// PUSH_B   | second push cycle
// POP_A    | first pop cycle
// POP_B    | second pop cycle
// POP_WAIT | stack presents registered pop data
// DONE     | one-cycle completion, new_pc valid
module chip8_call_ret_ctrl
    import chip8_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        reset,
    input  logic        call_req,
    input  logic        ret_req,
    input  logic [15:0] pc_in,
    input  logic [11:0] target,
    output logic        busy,
    output logic        done,
    output logic [15:0] new_pc,
    output logic        stk_fault,
    output logic [4:0]  depth,
    output logic [1:0]  stk_we,
    output logic [15:0] stk_writedata,
    input  logic [15:0] stk_outdata
);

    localparam logic [4:0] DEPTH_MAX = 5'(DEPTH);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] ret_addr;
    logic [15:0] call_tgt;
    logic        full;
    logic        empty;

    assign full  = (depth == DEPTH_MAX);
    assign empty = (depth == 5'd0);

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are decoded from state alone so reset clears them without waiting for an edge.
    always_comb begin
        state_nxt     = state;
        stk_we        = WE_NONE;
        stk_writedata = 16'h0000;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (call_req) begin
                    state_nxt = full ? DONE : PUSH_A;
                end else if (ret_req) begin
                    state_nxt = empty ? DONE : POP_A;
                end
            end
            PUSH_A: begin
                stk_we        = WE_PUSH;
                stk_writedata = ret_addr;
                state_nxt     = PUSH_B;
            end
            PUSH_B: begin
                stk_we        = WE_PUSH;
                stk_writedata = ret_addr;
                state_nxt     = DONE;
            end
            POP_A: begin
                stk_we    = WE_POP;
                state_nxt = POP_B;
            end
            POP_B: begin
                stk_we    = WE_POP;
                state_nxt = POP_WAIT;
            end
            POP_WAIT: begin
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            ret_addr  <= 16'h0000;
            call_tgt  <= 16'h0000;
            new_pc    <= 16'h0000;
            depth     <= 5'd0;
            stk_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (call_req) begin
                        if (full) begin
                            new_pc    <= next_instr(pc_in);
                            stk_fault <= 1'b1;
                        end else begin
                            ret_addr <= next_instr(pc_in);
                            call_tgt <= {4'h0, target};
                        end
                    end else if (ret_req && empty) begin
                        new_pc    <= next_instr(pc_in);
                        stk_fault <= 1'b1;
                    end
                end
                PUSH_B: begin
                    new_pc <= call_tgt;
                    depth  <= depth + 5'd1;
                end
                POP_WAIT: begin
                    new_pc <= stk_outdata;
                    depth  <= depth - 5'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip8_call_ret_ctrl.sv
// Self-checking bench for chip8_call_ret_ctrl: directed corner cases plus
// randomized call/ret traffic against a queue-based return-stack model.
module tb_chip8_call_ret_ctrl;
    import chip8_pkg::*;

    localparam int TB_DEPTH = 16;

    logic        cpu_clk = 1'b0;
    logic        reset = 1'b1;
    logic        call_req = 1'b0;
    logic        ret_req = 1'b0;
    logic [15:0] pc_in = 16'h0000;
    logic [11:0] target = 12'h000;
    logic        busy;
    logic        done;
    logic [15:0] new_pc;
    logic        stk_fault;
    logic [4:0]  depth;
    logic [1:0]  stk_we;
    logic [15:0] stk_writedata;
    logic [15:0] stk_outdata = 16'h0000;

    chip8_call_ret_ctrl #(.DEPTH(TB_DEPTH)) dut (
        .cpu_clk       (cpu_clk),
        .reset         (reset),
        .call_req      (call_req),
        .ret_req       (ret_req),
        .pc_in         (pc_in),
        .target        (target),
        .busy          (busy),
        .done          (done),
        .new_pc        (new_pc),
        .stk_fault     (stk_fault),
        .depth         (depth),
        .stk_we        (stk_we),
        .stk_writedata (stk_writedata),
        .stk_outdata   (stk_outdata)
    );

    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // External stack: commits a push after its second cycle, presents the top
    // entry one cycle after the first pop cycle, removes it after the second.
    logic [15:0] stk_mem[$];
    bit          stk_phase;

    always @(posedge cpu_clk or posedge reset) begin
        if (reset) begin
            stk_mem.delete();
            stk_phase = 1'b0;
            stk_outdata <= 16'h0000;
        end else if (stk_we == WE_PUSH) begin
            if (stk_phase) stk_mem.push_back(stk_writedata);
            stk_phase = !stk_phase;
        end else if (stk_we == WE_POP) begin
            if (!stk_phase) begin
                stk_outdata <= (stk_mem.size() > 0) ? stk_mem[$] : 16'hDEAD;
            end else if (stk_mem.size() > 0) begin
                void'(stk_mem.pop_back());
            end
            stk_phase = !stk_phase;
        end else begin
            stk_phase = 1'b0;
        end
    end

    // Reference: list of return addresses and a sticky fault bit.
    logic [15:0] ref_q[$];
    bit          ref_fault;

    task automatic do_reset();
        @(negedge cpu_clk);
        reset    = 1'b1;
        call_req = 1'b0;
        ret_req  = 1'b0;
        @(negedge cpu_clk);
        @(negedge cpu_clk);
        reset = 1'b0;
        ref_q.delete();
        ref_fault = 1'b0;
    endtask

    task automatic run_op(input bit c, input bit r, input logic [15:0] pc,
                          input logic [11:0] t, output logic [15:0] got_pc);
        bit          is_call;
        bit          is_ret;
        bit          ovf;
        bit          unf;
        int          exp_lat;
        int          exp_push;
        int          exp_pop;
        logic [15:0] exp_wd;
        logic [15:0] exp_pc;
        int          lat;
        int          pushes;
        int          pops;
        int          bad_wd;
        int          not_busy;

        is_call  = c;
        is_ret   = !c && r;
        ovf      = is_call && (ref_q.size() == TB_DEPTH);
        unf      = is_ret && (ref_q.size() == 0);
        exp_lat  = (ovf || unf) ? 1 : (is_call ? 3 : 4);
        exp_push = (is_call && !ovf) ? 2 : 0;
        exp_pop  = (is_ret && !unf) ? 2 : 0;
        exp_wd   = pc + 16'd2;
        if (ovf || unf) begin
            exp_pc    = pc + 16'd2;
            ref_fault = 1'b1;
        end else if (is_call) begin
            exp_pc = {4'h0, t};
            ref_q.push_back(pc + 16'd2);
        end else begin
            exp_pc = ref_q.pop_back();
        end

        @(negedge cpu_clk);
        call_req = c;
        ret_req  = r;
        pc_in    = pc;
        target   = t;

        lat = 0; pushes = 0; pops = 0; bad_wd = 0; not_busy = 0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            @(negedge cpu_clk);
            if (!busy) not_busy++;
            if (stk_we == WE_PUSH) begin
                pushes++;
                if (stk_writedata !== exp_wd) bad_wd++;
            end else begin
                if (stk_we == WE_POP) pops++;
                else if (stk_we != WE_NONE) bad_wd++;
                if (stk_writedata !== 16'h0000) bad_wd++;
            end
            if (done) begin
                lat = cyc;
                break;
            end
            // Requests and operands during a busy operation must be ignored.
            call_req = 1'($urandom_range(0, 1));
            ret_req  = 1'($urandom_range(0, 1));
            pc_in    = 16'($urandom);
            target   = 12'($urandom);
        end
        call_req = 1'b0;
        ret_req  = 1'b0;

        check("latency", lat, exp_lat);
        check("push_cycles", pushes, exp_push);
        check("pop_cycles", pops, exp_pop);
        check("stk_writedata", bad_wd, 0);
        check("busy_during_op", not_busy, 0);
        check("new_pc", new_pc, exp_pc);
        check("depth", depth, ref_q.size());
        check("stk_fault", stk_fault, ref_fault);
        got_pc = new_pc;

        @(negedge cpu_clk);
        check("done_pulse_width", done, 0);
        check("idle_busy", busy, 0);
        check("new_pc_hold", new_pc, exp_pc);
    endtask

    logic [15:0] got;

    initial begin
        // Reset state.
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_stk_we", stk_we, WE_NONE);
        check("rst_wd", stk_writedata, 0);
        check("rst_new_pc", new_pc, 0);
        check("rst_depth", depth, 0);
        check("rst_fault", stk_fault, 0);
        do_reset();

        // Basic call then return.
        run_op(1, 0, 16'h0200, 12'h3A4, got);
        check("call_new_pc", got, 16'h03A4);
        run_op(0, 1, 16'h03A4, 12'h000, got);
        check("ret_new_pc", got, 16'h0202);

        // PC wrap on the pushed return address.
        run_op(1, 0, 16'hFFFE, 12'h5B6, got);
        run_op(0, 1, 16'h05B6, 12'h000, got);
        check("wrap_ret_pc", got, 16'h0000);

        // Call wins over a simultaneous ret.
        run_op(1, 1, 16'h0300, 12'h777, got);
        check("both_call_pc", got, 16'h0777);

        // Reset in PUSH_B clears everything before the next edge.
        @(negedge cpu_clk);
        call_req = 1'b1;
        pc_in    = 16'h0400;
        target   = 12'h123;
        @(negedge cpu_clk);
        call_req = 1'b0;
        check("midrst_push_a", stk_we, WE_PUSH);
        @(negedge cpu_clk);
        check("midrst_push_b", stk_we, WE_PUSH);
        #1 reset = 1'b1;
        #1;
        check("midrst_stk_we", stk_we, WE_NONE);
        check("midrst_depth", depth, 0);
        check("midrst_busy", busy, 0);
        check("midrst_new_pc", new_pc, 0);
        check("midrst_wd", stk_writedata, 0);
        @(negedge cpu_clk);
        reset = 1'b0;
        ref_q.delete();
        ref_fault = 1'b0;

        // Fill the stack, then overflow on the 17th call.
        for (int i = 0; i < TB_DEPTH; i++) begin
            run_op(1, 0, 16'(16'h1000 + 16'(i * 4)), 12'(12'h800 + i), got);
        end
        run_op(1, 0, 16'h2222, 12'hABC, got);
        check("ovf_new_pc", got, 16'h2224);
        check("ovf_depth", depth, TB_DEPTH);
        run_op(0, 1, 16'h080F, 12'h000, got);
        check("after_ovf_ret", got, 16'h1000 + 16'((TB_DEPTH - 1) * 4) + 16'd2);

        // Underflow on an empty stack.
        do_reset();
        run_op(0, 1, 16'h0FFE, 12'h000, got);
        check("unf_new_pc", got, 16'h1000);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            int k;
            if (i % 100 == 0) do_reset();
            k = $urandom_range(0, 9);
            run_op(k < 5 || k == 9, k >= 5, 16'($urandom), 12'($urandom), got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
